// File: rtl/ram_sp_if.sv
// Access bus for the single-port RAM: one shared address, write data/enable in, registered read data out.
interface ram_sp_if #(
    parameter int unsigned AWID = 8,
    parameter int unsigned DWID = 16
);
    logic            i_we;
    logic [AWID-1:0] i_addr;
    logic [DWID-1:0] i_dat;
    logic [DWID-1:0] o_dat;

    modport master (output i_we, i_addr, i_dat, input o_dat);
    modport slave  (input i_we, i_addr, i_dat, output o_dat);
endinterface

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with read-first behaviour and a registered read port.
// Out-of-range addresses (>= DEPTH) ignore writes and read back as zero.
module ram_sp #(
    parameter int unsigned AWID  = 8,
    parameter int unsigned DWID  = 16,
    parameter int unsigned DEPTH = 2**AWID
) (
    input  logic     clk,
    input  logic     rst_n,
    ram_sp_if.slave  bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWID:0] DEPTH_W = (AWID+1)'(DEPTH);

    // Zero at time 0; reset deliberately leaves the array untouched.
    logic [DWID-1:0] mem [DEPTH] = '{default: '0};

    logic             in_range_c;
    logic [IDX_W-1:0] idx_c;
    logic [DWID-1:0]  rd_c;

    always_comb begin
        in_range_c = ({1'b0, bus.i_addr} < DEPTH_W);
        idx_c      = bus.i_addr[IDX_W-1:0];
        rd_c       = '0;
        if (in_range_c) begin
            rd_c = mem[idx_c];
        end
    end

    // Write and read share one edge; the NBA ordering gives read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_dat <= '0;
        end else begin
            if (bus.i_we && in_range_c) begin
                mem[idx_c] <= bus.i_dat;
            end
            bus.o_dat <= rd_c;
        end
    end

endmodule

// File: tb/tb_ram_sp.sv
// Directed bench for ram_sp: three instances cover full depth, reduced depth and a narrow word.
module tb_ram_sp;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ram_sp_if #(.AWID(8),  .DWID(16)) a_if ();
    ram_sp_if #(.AWID(8),  .DWID(16)) b_if ();
    ram_sp_if #(.AWID(10), .DWID(4))  c_if ();

    ram_sp #(8, 16)      u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    ram_sp #(8, 16, 200) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    ram_sp #(10, 4)      u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, act, exp, $time);
        end
    endtask

    // Same address/data to all instances; a/b and c have separate write enables.
    task automatic drive(input logic we_ab, input logic we_c, input int addr, input logic [15:0] dat);
        a_if.i_we   = we_ab;
        a_if.i_addr = 8'(addr);
        a_if.i_dat  = dat;
        b_if.i_we   = we_ab;
        b_if.i_addr = 8'(addr);
        b_if.i_dat  = dat;
        c_if.i_we   = we_c;
        c_if.i_addr = 10'(addr);
        c_if.i_dat  = 4'(dat);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                          input logic [15:0] ec);
        check({tag, "_a"}, a_if.o_dat, ea);
        check({tag, "_b"}, b_if.o_dat, eb);
        check({tag, "_c"}, {12'h000, c_if.o_dat}, ec);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b1, 1'b1, 5, 16'hAAAA);

        // Held reset: output stays zero and writes are blocked.
        for (int i = 0; i < 3; i++) begin
            step();
            check3("rst_hold", 16'h0000, 16'h0000, 16'h0000);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5, 16'h0000);
        step();
        check3("init_zero", 16'h0000, 16'h0000, 16'h0000);

        // Fill: a/b get mem[x]=x (b ignores x>=200), c gets mem[x]=x[3:0].
        for (int x = 0; x < 1024; x++) begin
            drive(x < 256, 1'b1, x, 16'(x));
            step();
        end

        drive(1'b0, 1'b0, 0, 16'h0000);
        for (int x = 0; x < 1024; x++) begin
            drive(1'b0, 1'b0, x, 16'h0000);
            step();
            check("rd_c", {12'h000, c_if.o_dat}, 16'(x & 15));
            if (x < 256) begin
                check("rd_a", a_if.o_dat, 16'(x));
                check("rd_b", b_if.o_dat, (x < 200) ? 16'(x) : 16'h0000);
            end
        end
        check("top_c", {12'h000, c_if.o_dat}, 16'h000F);

        // Read-first on address 7, then the new word on the following read.
        drive(1'b1, 1'b1, 7, 16'hBEEF);
        step();
        check3("rdw_old", 16'h0007, 16'h0007, 16'h0007);
        drive(1'b0, 1'b0, 7, 16'h0000);
        step();
        check3("rdw_new", 16'hBEEF, 16'hBEEF, 16'h000F);

        // No combinational path: changing the address alone does not move o_dat.
        drive(1'b0, 1'b0, 5, 16'h0000);
        #2;
        check3("no_comb", 16'hBEEF, 16'hBEEF, 16'h000F);

        // Mid-cycle asynchronous clear, then a blocked write during reset.
        rst_n = 1'b0;
        #1;
        check3("async_clr", 16'h0000, 16'h0000, 16'h0000);
        drive(1'b1, 1'b1, 200, 16'hFFFF);
        step();
        check3("rst_block", 16'h0000, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 200, 16'h0000);
        step();
        check3("survive", 16'h00C8, 16'h0000, 16'h0008);

        // Out-of-range write on b; a and c take it as an ordinary write.
        drive(1'b1, 1'b1, 250, 16'h1234);
        step();
        drive(1'b0, 1'b0, 250, 16'h0000);
        step();
        check3("oor_250", 16'h1234, 16'h0000, 16'h0004);
        drive(1'b0, 1'b0, 199, 16'h0000);
        step();
        check3("edge_199", 16'h00C7, 16'h00C7, 16'h0007);
        drive(1'b0, 1'b0, 1023, 16'h0000);
        step();
        check3("edge_3ff", 16'h00FF, 16'h0000, 16'h000F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sp.md
Name: ram_sp

Overview:
- Single-port synchronous RAM: one write port and one registered read port sharing a single address bus.
- Generic storage primitive, sized by parameters and inferable as FPGA block RAM.
- Instantiated positionally as #(AWID, DWID); parameter order is fixed: AWID first, DWID second, DEPTH third.

Parameters:
- AWID, 8, address width in bits.
- DWID, 16, data word width in bits; supported values 2, 4, 8 and 16 (any value ≥1 legal).
- DEPTH, 2**AWID, number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2**AWID.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset; clears the output register only.
- i_we  input  1  write enable; sampled on the rising edge of clk.
- i_addr  input  AWID  word address for both write and read.
- i_dat  input  DWID  write data.
- o_dat  output  DWID  registered read data.

Behaviour:
- Storage: array of DEPTH words, each DWID bits. Contents initialise to all zeros at time 0 (simulation initial block / FPGA init). Reset does not clear contents.
- Reset:
  - rst_n low forces o_dat to 0 immediately, independent of clk.
  - While rst_n is low, o_dat stays 0 and writes are blocked.
  - Release is synchronous in effect: the first edge with rst_n high performs normal operation.
- Write: at a rising edge with rst_n=1, i_we=1 and i_addr<DEPTH, mem[i_addr] <= i_dat. Writes to i_addr ≥ DEPTH are ignored.
- Read:
  - Every rising edge with rst_n=1 updates o_dat <= mem[i_addr], regardless of i_we.
  - Latency is 1 cycle: an address presented before edge N produces data after edge N.
  - Reads of i_addr ≥ DEPTH return 0.
- Read-during-write to the same address: read-first. o_dat shows the old contents; the new data is visible on the next read.
- o_dat holds its value only through reset. There is no read enable, so o_dat tracks i_addr every cycle.
- No X propagation from the memory array after initialisation. Unknown address bits in simulation may yield X.
- Fully synchronous apart from the reset clear; no combinational path from inputs to o_dat.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving i_addr=5 -> o_dat=0 throughout. Assert rst_n=0 mid-cycle after o_dat is nonzero -> o_dat drops to 0 without waiting for a clock edge.
- Fill/readback (AWID=8, DWID=16):
  - Write mem[a]=a for a=0..255 with i_we=1, one write per cycle.
  - Set i_we=0 and read a=0..255 -> o_dat equals a one cycle after each address.
- Read-first: mem[7]=0x0007; write i_dat=0xBEEF at addr 7 -> o_dat=0x0007 after that edge. Next read of 7 -> 0xBEEF.
- Contents survive reset: after the fill, pulse rst_n low, then read addr 200 -> o_dat=200 (0x00C8).
- Out of range (AWID=8, DEPTH=200):
  - Write 0x1234 to addr 250, then read 250 -> 0.
  - Addr 199 reads back its written value.
- Narrow width (DWID=4, AWID=10):
  - Write mem[a]=a[3:0] across all 1024 words.
  - Readback matches; addr 0x3FF -> 0xF.
